// File: rtl/pll_ctrl_pkg.sv
// pll_ctrl_pkg: state encoding and status widths shared by the PLL lock sequencer
package pll_ctrl_pkg;
  localparam int RETRY_W = 4;
  localparam int LOSS_W = 16;
  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    DEBOUNCE  = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } state_t;
endpackage

// File: rtl/pll_lock_ctrl_sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous level
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic m;
  always_ff @(posedge clk)
    if (rst) {q, m} <= '0;
    else {q, m} <= {m, d};
endmodule

// File: rtl/pll_lock_ctrl.sv
// pll_lock_ctrl: PLL reset/lock sequencer; define PLL_LOCK_CTRL_STATS_EN for the lock-loss counter
module pll_lock_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int RST_CYCLES      = 16,
  parameter int DEBOUNCE_CYCLES = 1024,
  parameter int TIMEOUT_CYCLES  = 500000,
  parameter int MAX_RETRY       = 3
) (
  input  logic               refclk,
  input  logic               rst,
  input  logic               pll_locked,
  input  logic               relock_req,
  output logic               pll_rst,
  output logic               sys_rst,
  output logic               ready,
  output logic               fail,
  output logic [RETRY_W-1:0] retry_cnt,
  output logic [2:0]         state,
  output logic [LOSS_W-1:0]  loss_cnt
);
  localparam int MAX_A = RST_CYCLES > DEBOUNCE_CYCLES ? RST_CYCLES : DEBOUNCE_CYCLES;
  localparam int MAX_C = MAX_A > TIMEOUT_CYCLES ? MAX_A : TIMEOUT_CYCLES;
  localparam int CW = $clog2(MAX_C + 1);
  state_t st;
  logic [CW-1:0] cnt, cnt_inc;
  logic locked_s;
  sync_2ff u_sync (.clk(refclk), .rst(rst), .d(pll_locked), .q(locked_s));
  assign cnt_inc = &cnt ? cnt : cnt + 1'b1;
  always_ff @(posedge refclk)
    if (rst || relock_req) begin
      st        <= PLL_RST;
      cnt       <= '0;
      retry_cnt <= '0;
    end else
      case (st)
        PLL_RST:
          if (cnt == CW'(RST_CYCLES - 1)) begin
            st  <= WAIT_LOCK;
            cnt <= '0;
          end else cnt <= cnt_inc;
        WAIT_LOCK:
          if (locked_s) begin
            st  <= DEBOUNCE;
            cnt <= '0;
          end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            cnt <= '0;
            if (retry_cnt < RETRY_W'(MAX_RETRY)) begin
              st        <= PLL_RST;
              retry_cnt <= retry_cnt + 1'b1;
            end else st <= FAIL;
          end else cnt <= cnt_inc;
        DEBOUNCE:
          if (!locked_s) begin
            st  <= WAIT_LOCK;
            cnt <= '0;
          end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            st        <= RUN;
            cnt       <= '0;
            retry_cnt <= '0;
          end else cnt <= cnt_inc;
        RUN:
          if (!locked_s) begin
            st  <= PLL_RST;
            cnt <= '0;
          end
        FAIL: st <= FAIL;
        default: begin
          st  <= PLL_RST;
          cnt <= '0;
        end
      endcase
  assign state   = st;
  assign pll_rst = st == PLL_RST;
  assign sys_rst = st != RUN;
  assign ready   = st == RUN;
  assign fail    = st == FAIL;
`ifdef PLL_LOCK_CTRL_STATS_EN
  // only genuine lock loss in RUN counts; a relock request is not a loss event
  always_ff @(posedge refclk)
    if (rst) loss_cnt <= '0;
    else if (!relock_req && st == RUN && !locked_s && !(&loss_cnt)) loss_cnt <= loss_cnt + 1'b1;
`else
  assign loss_cnt = '0;
`endif
endmodule
